trng_output_sched: RTL

Output scheduler for the TRNG entropy path. It takes the raw entropy bit stream and runs the repetition-count health test on it. It then sequences the hash engine over 448-bit message blocks and arbitrates the single UART byte transmitter between raw bytes and hash digest bytes, selected by `ctrl_mode`. It sits between the entropy sampler and the hash engine / UART transmitter inside the TRNG top.

---
 rtl/trng_pkg.sv | 21 ++
 rtl/trng_output_sched_if.sv | 19 +
 rtl/trng_rct.sv | 36 +++
 rtl/trng_output_sched.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// trng_pkg: shared state encoding and default sizes
// for the TRNG output scheduler.
package trng_pkg;

  localparam int DEF_RCT_CUTOFF   = 32;
  localparam int DEF_BLOCK_BITS   = 448;
  localparam int DEF_DIGEST_BYTES = 32;

  localparam int IDX_W  = $clog2(DEF_BLOCK_BITS);
  localparam int ADDR_W = $clog2(DEF_DIGEST_BYTES);
  localparam int RUN_W  = $clog2(DEF_RCT_CUTOFF + 1);

  typedef enum logic [2:0] {
    S_COLLECT,
    S_HASH_START,
    S_HASH_WAIT,
    S_DIG_READ,
    S_DIG_SEND
  } state_t;

endpackage

// File: rtl/trng_output_sched_if.sv
// trng_output_sched_if: byte stream towards the UART
// transmitter, valid/ready handshake.
interface trng_output_sched_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/trng_rct.sv
// trng_rct: repetition-count health test, flags the
// accepted bit that makes the run reach the cutoff.
module trng_rct #(
  parameter int CUTOFF = 32,
  parameter int RUN_W  = 6
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_valid,
  input  logic i_bit,
  output logic o_fail
);

  logic [RUN_W-1:0] r_cnt;
  logic             r_last;
  logic [RUN_W-1:0] w_run;

  always_comb begin
    w_run = RUN_W'(1);
    if (r_cnt != '0 && i_bit == r_last)
      w_run = r_cnt + 1'b1;
    o_fail = i_valid && (w_run == RUN_W'(CUTOFF));
  end

  // a failing bit starts a fresh run of length 1
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_last <= 1'b0;
    end else if (i_valid) begin
      r_cnt  <= o_fail ? RUN_W'(1) : w_run;
      r_last <= i_bit;
    end
  end

endmodule

// File: rtl/trng_output_sched.sv
// trng_output_sched: RCT health test, hash block sequencing and
// UART arbitration between raw bytes and digest bytes.
module trng_output_sched
  import trng_pkg::*;
#(
  parameter int RCT_CUTOFF   = DEF_RCT_CUTOFF,
  parameter int BLOCK_BITS   = DEF_BLOCK_BITS,
  parameter int DIGEST_BYTES = DEF_DIGEST_BYTES
) (
  input  logic              TRNG_Clock,
  input  logic              TRNG_Reset,
  input  logic              ctrl_mode,
  input  logic              sample_valid,
  input  logic              sample_bit,
  output logic              blk_bit_valid,
  output logic              blk_bit,
  output logic [IDX_W-1:0]  blk_bit_idx,
  output logic              hash_start,
  input  logic              hash_done,
  output logic [ADDR_W-1:0] digest_rd_addr,
  input  logic [7:0]        digest_rd_data,
  trng_output_sched_if.master tx,
  output logic              failure,
  output logic              overrun,
  output logic              hash_rdy
);

  state_t r_state, w_next;

  logic [IDX_W-1:0]  r_pos;
  logic              r_mode;
  logic [6:0]        r_shift;
  logic [7:0]        r_hold;
  logic              r_hfull;
  logic              r_fail;
  logic              r_ovr;
  logic              r_rdy;
  logic [ADDR_W-1:0] r_addr;

  logic w_acc, w_mode, w_rfail, w_fwd;
  logic w_blk_last, w_byte_done;
  logic w_dig_tx, w_hold_tx, w_drain, w_addr_last;

  trng_rct #(
    .CUTOFF (RCT_CUTOFF),
    .RUN_W  ($clog2(RCT_CUTOFF + 1))
  ) u_rct (
    .i_clk   (TRNG_Clock),
    .i_rst   (TRNG_Reset),
    .i_valid (w_acc),
    .i_bit   (sample_bit),
    .o_fail  (w_rfail)
  );

  // mode only follows ctrl_mode at a block/byte boundary
  assign w_acc       = sample_valid & ~TRNG_Reset
                     & (r_state == S_COLLECT);
  assign w_mode      = (r_pos == '0) ? ctrl_mode : r_mode;
  assign w_fwd       = w_acc & ~w_rfail;
  assign w_blk_last  = w_fwd & ~w_mode
                     & (r_pos == IDX_W'(BLOCK_BITS - 1));
  assign w_byte_done = w_fwd & w_mode & (r_pos == IDX_W'(7));
  assign w_dig_tx    = (r_state == S_DIG_SEND);
  assign w_hold_tx   = r_hfull & (r_state != S_DIG_READ)
                     & ~w_dig_tx;
  assign w_drain     = w_hold_tx & tx.tx_ready;
  assign w_addr_last = (r_addr == ADDR_W'(DIGEST_BYTES - 1));

  always_ff @(posedge TRNG_Clock) begin
    if (TRNG_Reset) r_state <= S_COLLECT;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_COLLECT:    if (w_blk_last) w_next = S_HASH_START;
      S_HASH_START: w_next = S_HASH_WAIT;
      S_HASH_WAIT:  if (hash_done) w_next = S_DIG_READ;
      S_DIG_READ:   w_next = S_DIG_SEND;
      S_DIG_SEND:
        if (tx.tx_ready)
          w_next = w_addr_last ? S_COLLECT : S_DIG_READ;
      default:      w_next = S_COLLECT;
    endcase
  end

  always_comb begin
    hash_start    = (r_state == S_HASH_START);
    blk_bit_valid = w_fwd & ~w_mode;
    blk_bit       = blk_bit_valid & sample_bit;
    blk_bit_idx   = blk_bit_valid ? r_pos : '0;
    tx.tx_valid   = w_dig_tx | w_hold_tx;
    tx.tx_data    = 8'h00;
    if (w_dig_tx)       tx.tx_data = digest_rd_data;
    else if (w_hold_tx) tx.tx_data = r_hold;
  end

  always_ff @(posedge TRNG_Clock) begin
    if (TRNG_Reset) begin
      r_pos   <= '0;
      r_mode  <= 1'b0;
      r_shift <= '0;
      r_hold  <= '0;
      r_hfull <= 1'b0;
      r_fail  <= 1'b0;
      r_ovr   <= 1'b0;
      r_rdy   <= 1'b0;
      r_addr  <= '0;
    end else begin
      if (r_pos == '0) r_mode <= ctrl_mode;
      if (w_acc & w_rfail) begin
        r_pos  <= '0;
        r_fail <= 1'b1;
      end else if (w_fwd) begin
        if (w_blk_last | w_byte_done) begin
          r_pos  <= '0;
          r_fail <= 1'b0;
        end else begin
          r_pos <= r_pos + 1'b1;
        end
        if (w_mode) r_shift <= {r_shift[5:0], sample_bit};
      end
      // a drain on the same edge frees the holding register
      r_ovr <= w_byte_done & r_hfull & ~w_drain;
      if (w_byte_done & (~r_hfull | w_drain)) begin
        r_hold  <= {r_shift, sample_bit};
        r_hfull <= 1'b1;
      end else if (w_drain) begin
        r_hfull <= 1'b0;
      end
      if (r_state == S_HASH_WAIT && hash_done) begin
        r_rdy  <= 1'b1;
        r_addr <= '0;
      end
      if (w_dig_tx && tx.tx_ready) begin
        if (w_addr_last) begin
          r_rdy  <= 1'b0;
          r_addr <= '0;
        end else begin
          r_addr <= r_addr + 1'b1;
        end
      end
    end
  end

  assign failure        = r_fail;
  assign overrun        = r_ovr;
  assign hash_rdy       = r_rdy;
  assign digest_rd_addr = r_addr;

endmodule
